// File: rtl/sparc_pkg.sv
// sparc_pkg: shared fetch types and constants for the SPARC fetch path.
package sparc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} fetch_state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0100_0000;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem req/ack, decode valid/ready and redirect signals of the fetch sequencer.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_annul;
  logic        fetch_err;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, br_valid, br_target, br_annul
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, br_valid, br_target, br_annul
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: clear/enable wait counter with a registered expired flag at TIMEOUT.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  logic         r_expired;
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (i_en) begin
      r_cnt     <= r_cnt + W'(1);
      r_expired <= r_cnt == W'(TIMEOUT - 1);
    end
  end
  assign o_expired = r_expired;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/nPC owner issuing imem reads and presenting words to decode.
// Optional SPARC_ANNUL_EN squashes an annulled delay slot instead of presenting it.
module fetch_sequencer
  import sparc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int          TIMEOUT   = 16
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.master bus
);
  fetch_state_t r_state;
  logic [31:0]  r_pc, r_npc, r_instr, r_instr_pc;
  logic         r_req, r_valid, r_err, r_squash;
  logic         w_expired, w_squash_next, w_unused_tgt;
  logic [31:0]  w_target;
  assign w_target     = {bus.br_target[31:2], 2'b00};
  assign w_unused_tgt = ^bus.br_target[1:0];
`ifdef SPARC_ANNUL_EN
  assign w_squash_next = bus.br_valid & bus.br_annul;
`else
  logic w_unused_annul;
  assign w_unused_annul = bus.br_annul;
  assign w_squash_next  = 1'b0;
`endif
  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (r_state != REQ || bus.imem_ack),
    .i_en      (r_state == REQ),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_VEC;
      r_npc      <= RESET_VEC + WORD_BYTES;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_squash   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ack) begin
            // a squashed delay slot still advances PC but goes straight to the next fetch
            r_instr    <= bus.imem_rdata;
            r_instr_pc <= r_pc;
            r_pc       <= r_npc;
            r_npc      <= r_npc + WORD_BYTES;
            r_squash   <= 1'b0;
            r_state    <= r_squash ? REQ : HOLD;
            r_req      <= r_squash;
            r_valid    <= !r_squash;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= HALT;
            r_req   <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            r_state  <= REQ;
            r_req    <= 1'b1;
            r_valid  <= 1'b0;
            r_squash <= w_squash_next;
            if (bus.br_valid) r_npc <= w_target;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.fetch_err   = r_err;
endmodule
